ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as 0xED LED set or 0xFF reset, using the keyboard's own ps2_kbd_clk/ps2_kbd_data lines.
- It is the transmit counterpart of the keyboard receiver.
- The lines are open-drain, so the block only drives low through output-enable signals.
- It runs in the clk_sys domain, 24 MHz.

---
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (open-drain, oe-driven)
module ps2_host_tx #(
    parameter int CLK_HZ      = 24000000,
    parameter int INHIBIT_US  = 120,
    parameter int START_TO_US = 15000,
    parameter int XFER_TO_US  = 2000,
    parameter int FILTER      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CYC_PER_US = CLK_HZ / 1000000;
    localparam int INH_CYC    = CYC_PER_US * INHIBIT_US;
    localparam int START_CYC  = CYC_PER_US * START_TO_US;
    localparam int XFER_CYC   = CYC_PER_US * XFER_TO_US;
    localparam int MAX_CYC    = (START_CYC > XFER_CYC) ?
                                ((START_CYC > INH_CYC) ? START_CYC : INH_CYC) :
                                ((XFER_CYC > INH_CYC) ? XFER_CYC : INH_CYC);
    localparam int TW         = $clog2(MAX_CYC + 1);
    localparam int FW         = (FILTER > 1) ? $clog2(FILTER) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_BITS      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          clk_fall;

    logic [2:0]    state;
    logic [7:0]    shreg;
    logic          parity;
    logic [3:0]    bit_idx;
    logic [TW-1:0] timer;
    logic          xfer_expired;

    // Index 0 is the clock line, index 1 the data line; both idle high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            fcnt[0]  <= '0;
            fcnt[1]  <= '0;
            clk_fall <= 1'b0;
        end else begin
            sync1    <= {ps2_dat_i, ps2_clk_i};
            sync2    <= sync1;
            clk_fall <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER - 1)) begin
                    fcnt[i] <= '0;
                    filt[i] <= sync2[i];
                    if (i == 0) begin
                        clk_fall <= ~sync2[i];
                    end
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign xfer_expired = (timer == TW'(XFER_CYC - 1));
    assign tx_ready     = (state == S_IDLE);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            parity     <= 1'b0;
            bit_idx    <= '0;
            timer      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        parity     <= ~^tx_data;
                        err_code   <= 2'b00;
                        timer      <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    timer <= timer + 1'b1;
                    // Start bit goes out while the clock is still held low.
                    if (timer == TW'(INH_CYC - 2)) begin
                        ps2_dat_oe <= 1'b1;
                    end
                    if (timer == TW'(INH_CYC - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        timer      <= '0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (clk_fall) begin
                        ps2_dat_oe <= ~shreg[0];
                        bit_idx    <= 4'd1;
                        timer      <= '0;
                        state      <= S_BITS;
                    end else if (timer == TW'(START_CYC - 1)) begin
                        ps2_dat_oe <= 1'b0;
                        err        <= 1'b1;
                        err_code   <= 2'b01;
                        state      <= S_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_BITS: begin
                    timer <= timer + 1'b1;
                    if (clk_fall) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= S_ACK;
                        end else if (bit_idx == 4'd8) begin
                            ps2_dat_oe <= ~parity;
                        end else begin
                            ps2_dat_oe <= ~shreg[bit_idx[2:0]];
                        end
                    end else if (xfer_expired) begin
                        ps2_dat_oe <= 1'b0;
                        err        <= 1'b1;
                        err_code   <= 2'b10;
                        state      <= S_FAIL;
                    end
                end
                S_ACK: begin
                    timer <= timer + 1'b1;
                    if (clk_fall) begin
                        if (!filt[1]) begin
                            state <= S_WAIT_IDLE;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                            state    <= S_FAIL;
                        end
                    end else if (xfer_expired) begin
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        state    <= S_FAIL;
                    end
                end
                S_WAIT_IDLE: begin
                    timer <= timer + 1'b1;
                    if (filt == 2'b11) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (xfer_expired) begin
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        state    <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
